// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: two-flop synchronizer, divided-rate majority-free
// debounce (N consecutive equal samples), edge detection and sticky pending flags.
module gpio_in_filter #(
  parameter int WIDTH    = 32,
  parameter int FILT_LEN = 4,
  parameter int DIV_W    = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [DIV_W-1:0] div_val,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic             clr_stb,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] pend,
  output logic             irq
);

  logic [WIDTH-1:0]                sync1;
  logic [WIDTH-1:0]                sync2;
  logic [DIV_W-1:0]                presc_cnt;
  logic                            tick;
  logic [WIDTH-1:0][FILT_LEN-1:0]  hist;
  logic [WIDTH-1:0][FILT_LEN-1:0]  hist_nxt;
  logic [WIDTH-1:0]                filt;
  logic [WIDTH-1:0]                filt_nxt;
  logic [WIDTH-1:0]                rise_det;
  logic [WIDTH-1:0]                fall_det;
  logic [WIDTH-1:0]                clr_vec;
  logic [WIDTH-1:0]                pend_nxt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // >= rather than == so a div_val lowered below the running count wraps at once
  assign tick = (presc_cnt >= div_val);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    hist_nxt = hist;
    filt_nxt = filt;
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        hist_nxt[i] = {hist[i][FILT_LEN-2:0], sync2[i]};
        if (&hist_nxt[i]) begin
          filt_nxt[i] = 1'b1;
        end else if (~|hist_nxt[i]) begin
          filt_nxt[i] = 1'b0;
        end
      end
    end
  end

  assign rise_det = filt_nxt & ~filt;
  assign fall_det = ~filt_nxt & filt;
  assign clr_vec  = clr_stb ? clr_mask : '0;
  // Set wins over a simultaneous clear of the same bit
  assign pend_nxt = (pend & ~clr_vec) | (rise_det & rise_en) | (fall_det & fall_en);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hist <= '0;
      filt <= '0;
      pend <= '0;
    end else begin
      hist <= hist_nxt;
      filt <= filt_nxt;
      pend <= pend_nxt;
    end
  end

  assign iData = filt;
  assign irq   = |pend;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed self-checking bench for gpio_in_filter with hand-computed expectations.
module tb_gpio_in_filter;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] pin_in;
  logic [15:0] div_val;
  logic [31:0] rise_en;
  logic [31:0] fall_en;
  logic        clr_stb;
  logic [31:0] clr_mask;
  logic [31:0] iData;
  logic [31:0] pend;
  logic        irq;

  int n_assert;
  int n_fail;

  gpio_in_filter #(.WIDTH(32), .FILT_LEN(4), .DIV_W(16)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .pin_in   (pin_in),
    .div_val  (div_val),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .clr_stb  (clr_stb),
    .clr_mask (clr_mask),
    .iData    (iData),
    .pend     (pend),
    .irq      (irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic edges(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    HRESETn  = 1'b0;
    pin_in   = 32'hFFFF_FFFF;
    div_val  = 16'd0;
    rise_en  = 32'h0;
    fall_en  = 32'h0;
    clr_stb  = 1'b0;
    clr_mask = 32'h0;

    edges(3);
    check("rst_idata", iData, 32'h0);
    check("rst_pend", pend, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    pin_in  = 32'h0;
    rise_en = 32'h1;
    fall_en = 32'h80;
    HRESETn = 1'b1;
    edges(8);
    check("idle_idata", iData, 32'h0);

    // bit 0 step: accepted on the 6th edge after it is first sampled
    pin_in = 32'h1;
    edges(5);
    check("lat_edge5_idata", iData, 32'h0);
    check("lat_edge5_pend", pend, 32'h0);
    edges(1);
    check("lat_edge6_idata", iData, 32'h1);
    check("lat_edge6_pend", pend, 32'h1);
    check("lat_edge6_irq", {31'b0, irq}, 32'h1);

    // 3-cycle glitch on bit 3 is rejected
    rise_en = 32'h9;
    pin_in  = 32'h9;
    edges(3);
    pin_in  = 32'h1;
    edges(10);
    check("glitch_idata", iData, 32'h1);
    check("glitch_pend", pend, 32'h1);

    // mask without strobe does nothing
    clr_mask = 32'hFFFF_FFFF;
    edges(2);
    check("mask_no_stb_pend", pend, 32'h1);
    clr_mask = 32'h0;

    // bit 7 rises (not enabled), then falls (fall enabled)
    pin_in = 32'h81;
    edges(8);
    check("b7_rise_idata", iData, 32'h81);
    check("b7_rise_pend", pend, 32'h1);
    pin_in = 32'h01;
    edges(5);
    check("b7_fall_e5_pend", pend, 32'h1);
    edges(1);
    check("b7_fall_idata", iData, 32'h01);
    check("b7_fall_pend", pend, 32'h81);

    clr_stb  = 1'b1;
    clr_mask = 32'h80;
    edges(1);
    clr_stb  = 1'b0;
    clr_mask = 32'h0;
    check("clr_b7_pend", pend, 32'h1);

    // bit 0 falls (fall not enabled), then a rise coincides with a clear
    pin_in = 32'h0;
    edges(8);
    check("b0_fall_idata", iData, 32'h0);
    check("b0_fall_pend", pend, 32'h1);
    pin_in = 32'h1;
    edges(5);
    check("b0_rise_e5_idata", iData, 32'h0);
    clr_stb  = 1'b1;
    clr_mask = 32'h1;
    edges(1);
    clr_stb  = 1'b0;
    check("setclr_idata", iData, 32'h1);
    check("setclr_pend", pend, 32'h1);
    clr_stb = 1'b1;
    edges(1);
    clr_stb  = 1'b0;
    clr_mask = 32'h0;
    check("clr_b0_pend", pend, 32'h0);
    check("clr_b0_irq", {31'b0, irq}, 32'h0);

    // div_val=9: ticks every 10 cycles, bit 5 accepted on the 4th tick (edge 40)
    rise_en = 32'h29;
    div_val = 16'd9;
    pin_in  = 32'h21;
    edges(30);
    check("div9_e30_idata", iData, 32'h1);
    edges(9);
    check("div9_e39_idata", iData, 32'h1);
    edges(1);
    check("div9_e40_idata", iData, 32'h21);
    check("div9_e40_pend", pend, 32'h20);

    // count reaches 500 under div_val=1000, then div_val drops to 3
    div_val = 16'd1000;
    pin_in  = 32'h01;
    edges(500);
    check("div1000_idata", iData, 32'h21);
    div_val = 16'd3;
    edges(12);
    check("div3_e12_idata", iData, 32'h21);
    edges(1);
    check("div3_e13_idata", iData, 32'h01);
    check("div3_pend", pend, 32'h20);

    // reset with pins high: reset-to-high counts as a rising edge
    div_val = 16'd0;
    pin_in  = 32'h6;
    rise_en = 32'h2;
    fall_en = 32'h0;
    HRESETn = 1'b0;
    #1;
    check("async_rst_idata", iData, 32'h0);
    check("async_rst_pend", pend, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    edges(2);
    HRESETn = 1'b1;
    edges(5);
    check("postrst_e5_idata", iData, 32'h0);
    edges(1);
    check("postrst_e6_idata", iData, 32'h6);
    check("postrst_e6_pend", pend, 32'h2);
    check("postrst_e6_irq", {31'b0, irq}, 32'h1);

    // reset mid-filtering on bit 4 discards its partial history
    pin_in  = 32'h16;
    rise_en = 32'h12;
    edges(5);
    HRESETn = 1'b0;
    #1;
    HRESETn = 1'b1;
    edges(5);
    check("midrst_e5_idata", iData, 32'h0);
    check("midrst_e5_pend", pend, 32'h0);
    edges(1);
    check("midrst_e6_idata", iData, 32'h16);
    check("midrst_e6_pend", pend, 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of GPIO input bits.
REQ-002 SHALL have parameter FILT_LEN, default 4, legal range 2..8: consecutive equal samples needed to accept a new level.
REQ-003 SHALL have parameter DIV_W, default 16: width of the sample-period divider.
REQ-004 SHALL have port HCLK  input  1: single clock; all state on its rising edge.
REQ-005 SHALL have port HRESETn  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port pin_in  input  WIDTH: raw asynchronous external pin levels.
REQ-007 SHALL have port div_val  input  DIV_W: sample period is div_val+1 HCLK cycles.
REQ-008 SHALL have port rise_en  input  WIDTH: per-bit enable, rising edge sets pending.
REQ-009 SHALL have port fall_en  input  WIDTH: per-bit enable, falling edge sets pending.
REQ-010 SHALL have port clr_stb  input  1: one-cycle strobe qualifying clr_mask.
REQ-011 SHALL have port clr_mask  input  WIDTH: write-1-to-clear mask for pend.
REQ-012 SHALL have port iData  output  WIDTH: debounced pin levels, fed to the GPIO bus slave read path.
REQ-013 SHALL have port pend  output  WIDTH: sticky per-bit edge-pending flags.
REQ-014 SHALL have port irq  output  1: OR-reduction of pend.

Function
REQ-015 SHALL pass each pin_in bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-016 SHALL run a DIV_W-bit prescaler counting up each cycle; tick asserts when count >= div_val, and count returns to 0 on that cycle.
REQ-017 SHALL, with div_val=0, assert tick every cycle.
REQ-018 SHALL, if div_val is lowered below the current count, tick on the next cycle and wrap (no 2^DIV_W stall).
REQ-019 SHALL, on each tick, shift sync2 into a per-bit FILT_LEN-deep history register; no shift without tick.
REQ-020 SHALL update a filtered bit on the tick edge whose next-state history is all-ones (to 1) or all-zeros (to 0); otherwise hold.
REQ-021 SHALL drive iData directly from the filtered register (registered output, no combinational path from pin_in).
REQ-022 SHALL detect a rising edge when a filtered bit goes 0->1 and a falling edge on 1->0, on the same edge the filtered bit updates.
REQ-023 SHALL set pend[i] on that same edge if the matching rise_en[i]/fall_en[i] is 1.
REQ-024 SHALL clear pend[i] on the edge where clr_stb=1 and clr_mask[i]=1; clr_mask is ignored when clr_stb=0.
REQ-025 SHALL give set priority: a set and clear of the same bit in one cycle leaves pend[i]=1.
REQ-026 SHALL hold pend bits regardless of later changes to rise_en/fall_en; disabling an enable does not clear pend.
REQ-027 SHALL drive irq combinationally as |pend (from registers only).
REQ-028 SHALL have latency, with div_val=0, of exactly 2+FILT_LEN rising edges from the first edge capturing a stable new level into sync1 to the iData change (6 for default).
REQ-029 SHALL reject any pulse shorter than FILT_LEN ticks: iData and pend remain unchanged.

Reset
REQ-030 SHALL, while HRESETn=0, asynchronously force sync1, sync2, history, filtered, iData, pend, prescaler to 0 and irq to 0.
REQ-031 SHALL, after reset release with pin_in=1, raise iData after the REQ-028 latency and set pend only if rise_en=1 (a reset-to-high transition counts as a rising edge).
REQ-032 SHALL, on reset mid-filtering, discard partial history; no pend set from pre-reset samples.

Verification
REQ-033 SHALL cover: div_val=0, pin_in[0] 0->1 held -> iData[0]=1 exactly 6 edges later, rise_en[0]=1 gives pend[0]=1, irq=1 same edge.
REQ-034 SHALL cover: div_val=0, pin_in[3] high for 3 cycles then low -> iData[3] and pend[3] stay 0.
REQ-035 SHALL cover: div_val=9, pin_in[5] step -> iData[5] changes 2+ about 40 cycles later (4 ticks at 10-cycle period); no change at 3 ticks.
REQ-036 SHALL cover: pend=0x1, clr_stb=1 with clr_mask=0x1 on the same cycle as a new rising edge of bit 0 -> pend[0] stays 1; next clear -> 0, irq=0.
REQ-037 SHALL cover: clr_mask=0xFFFFFFFF with clr_stb=0 -> pend unchanged; fall_en[7]=1, pin 1->0 -> only pend[7] set.
REQ-038 SHALL cover: prescaler at count 500 with div_val=1000, div_val changed to 3 -> tick next cycle, then every 4 cycles.
